mem_access_unit: RTL and testbench

- Data-memory access stage that consumes the byte write mask from the store-mask generator, together with the ALU address, store data and access width.
- Issues one aligned 64-bit access per memory instruction on a valid/ready request, response bus.
- Stalls the pipeline until the access completes.
- Returns load data byte-extracted and sign/zero-extended to 64 bits.

---
 rtl/mem_access_unit.sv | 184 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Data-memory access stage: issues one aligned 64-bit bus access per load/store,
// stalls the pipeline until it completes and returns byte-extracted, extended load data.
module mem_access_unit #(
  parameter int unsigned RESP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [2:0]  req_width,
  input  logic [7:0]  req_wmask,
  output logic        stall,
  output logic        done,
  output logic [63:0] rdata,
  output logic        misalign,
  output logic        bus_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_addr,
  output logic        mem_wen,
  output logic [7:0]  mem_wmask,
  output logic [63:0] mem_wdata,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_data
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  localparam bit          TIMEOUT_EN   = (RESP_TIMEOUT != 32'd0);
  localparam logic [31:0] TIMEOUT_LAST = RESP_TIMEOUT - 32'd1;

  state_e      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [2:0]  width_q, width_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wmask_q, wmask_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] cnt_q, cnt_d;
  logic        valid_req;

  function automatic logic is_misaligned(input logic [2:0] width, input logic [2:0] lo);
    case (width)
      3'b001:        is_misaligned = (lo != 3'b000);
      3'b010, 3'b101: is_misaligned = (lo[1:0] != 2'b00);
      3'b011, 3'b110: is_misaligned = lo[0];
      default:       is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] extract_load(input logic [2:0] width, input logic [2:0] lo,
                                               input logic [63:0] data);
    logic [63:0] sh;
    sh = data >> {lo, 3'b000};
    case (width)
      3'b001:  extract_load = sh;
      3'b010:  extract_load = {{32{sh[31]}}, sh[31:0]};
      3'b011:  extract_load = {{48{sh[15]}}, sh[15:0]};
      3'b100:  extract_load = {{56{sh[7]}}, sh[7:0]};
      3'b101:  extract_load = {32'h0, sh[31:0]};
      3'b110:  extract_load = {48'h0, sh[15:0]};
      3'b111:  extract_load = {56'h0, sh[7:0]};
      default: extract_load = 64'h0;
    endcase
  endfunction

  assign valid_req = req_valid && (req_width != 3'b000);

  // State and latched-access registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= 64'h0;
      we_q    <= 1'b0;
      width_q <= 3'b000;
      wdata_q <= 64'h0;
      wmask_q <= 8'h00;
      rdata_q <= 64'h0;
      err_q   <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      width_q <= width_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    we_d          = we_q;
    width_d       = width_q;
    wdata_d       = wdata_q;
    wmask_d       = wmask_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    cnt_d         = cnt_q;
    stall         = 1'b0;
    done          = 1'b0;
    rdata         = rdata_q;
    misalign      = 1'b0;
    bus_err       = 1'b0;
    mem_req_valid = 1'b0;
    mem_addr      = 64'h0;
    mem_wen       = 1'b0;
    mem_wmask     = 8'h00;
    mem_wdata     = 64'h0;
    if (rst) begin
      rdata = 64'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid_req && is_misaligned(req_width, req_addr[2:0])) begin
            misalign = 1'b1;
          end else if (valid_req) begin
            stall   = 1'b1;
            addr_d  = req_addr;
            we_d    = req_we;
            width_d = req_width;
            wdata_d = req_wdata << {req_addr[2:0], 3'b000};
            wmask_d = req_we ? req_wmask : 8'h00;
            err_d   = 1'b0;
            state_d = S_REQ;
          end else begin
            stall = 1'b0;
          end
        end
        S_REQ: begin
          stall         = 1'b1;
          mem_req_valid = 1'b1;
          mem_addr      = {addr_q[63:3], 3'b000};
          mem_wen       = we_q;
          mem_wmask     = wmask_q;
          mem_wdata     = wdata_q;
          if (mem_req_ready) begin
            cnt_d   = 32'd0;
            state_d = S_WAIT;
          end else begin
            state_d = S_REQ;
          end
        end
        S_WAIT: begin
          stall = 1'b1;
          if (mem_resp_valid) begin
            if (!we_q) begin
              rdata_d = extract_load(width_q, addr_q[2:0], mem_resp_data);
            end else begin
              rdata_d = rdata_q;
            end
            state_d = S_DONE;
          end else if (TIMEOUT_EN && (cnt_q == TIMEOUT_LAST)) begin
            // Abandon the access; the error is reported in the DONE pulse
            err_d   = 1'b1;
            rdata_d = 64'h0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        S_DONE: begin
          done    = 1'b1;
          bus_err = err_q;
          rdata   = we_q ? 64'h0 : rdata_q;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected completions are queued when an access is
// issued and compared when done pulses; bus handshakes are driven per scenario.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [63:0] req_addr, req_wdata;
  logic [2:0]  req_width;
  logic [7:0]  req_wmask;
  logic        stall, done, misalign, bus_err;
  logic [63:0] rdata;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_resp_data;
  logic [7:0]  mem_wmask;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  mem_access_unit #(.RESP_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_width(req_width), .req_wmask(req_wmask),
    .stall(stall), .done(done), .rdata(rdata), .misalign(misalign), .bus_err(bus_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  // Issue one access, act as the memory, and check bus outputs and the completion.
  task automatic run_access(input logic we, input logic [2:0] width, input logic [63:0] addr,
                            input logic [63:0] wdata, input logic [7:0] wmask,
                            input logic [63:0] resp, input int ready_delay, input int resp_delay,
                            input logic [63:0] exp_maddr, input logic [63:0] exp_mwdata,
                            input logic [7:0] exp_mwmask, input logic [63:0] exp_rdata,
                            input logic exp_err, input string name);
    int   req_seen, wait_seen, wait_entry, exp_c;
    bit   got_done;
    exp_t e;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sb_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_width = width; req_addr = addr;
    req_wdata = wdata; req_wmask = wmask;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = resp;
    req_seen = 0; wait_seen = 0; wait_entry = -1; got_done = 1'b0;
    for (int c = 0; c < 40 && !got_done; c++) begin
      @(negedge clk);
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      if (c == 0) begin
        n_vec++;
        if (stall !== 1'b1 || mem_req_valid !== 1'b0 || misalign !== 1'b0 || done !== 1'b0) begin
          n_err++;
          $display("FAIL %s accept: stall=%b req_valid=%b misalign=%b done=%b, want 1 0 0 0",
                   name, stall, mem_req_valid, misalign, done);
        end
      end
      if (done === 1'b1) begin
        got_done = 1'b1;
        exp_c = (resp_delay < 0) ? wait_entry + 4 : wait_entry + resp_delay + 1;
        n_vec++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL %s done: unexpected completion, rdata=%h", name, rdata);
        end else begin
          e = sb_q.pop_front();
          if (rdata !== e.rdata || bus_err !== e.err || stall !== 1'b0 || c != exp_c) begin
            n_err++;
            $display("FAIL %s done: rdata=%h bus_err=%b stall=%b cycle=%0d, want %h %b 0 %0d",
                     name, rdata, bus_err, stall, c, e.rdata, e.err, exp_c);
          end
        end
      end else if (mem_req_valid === 1'b1) begin
        n_vec++;
        if (mem_addr !== exp_maddr || mem_wen !== we || mem_wmask !== exp_mwmask ||
            mem_wdata !== exp_mwdata || stall !== 1'b1) begin
          n_err++;
          $display("FAIL %s bus: addr=%h wen=%b wmask=%h wdata=%h stall=%b, want %h %b %h %h 1",
                   name, mem_addr, mem_wen, mem_wmask, mem_wdata, stall,
                   exp_maddr, we, exp_mwmask, exp_mwdata);
        end
        if (req_seen == ready_delay) begin
          mem_req_ready = 1'b1;
          wait_entry    = c + 1;
        end
        req_seen++;
      end else if (wait_entry >= 0 && c >= wait_entry) begin
        n_vec++;
        if (stall !== 1'b1 || bus_err !== 1'b0) begin
          n_err++;
          $display("FAIL %s wait: stall=%b bus_err=%b, want 1 0", name, stall, bus_err);
        end
        if (resp_delay >= 0 && wait_seen == resp_delay) mem_resp_valid = 1'b1;
        wait_seen++;
      end
    end
    if (!got_done) begin
      n_vec++;
      n_err++;
      $display("FAIL %s timeout: no done within 40 cycles", name);
      if (sb_q.size() != 0) e = sb_q.pop_front();
    end
  endtask

  // Drop the request and confirm the unit sits quietly with rdata retained.
  task automatic idle_check(input int n, input logic [63:0] exp_rdata, input string name);
    @(posedge clk); #1;
    req_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0 || stall !== 1'b0 || mem_req_valid !== 1'b0 || misalign !== 1'b0 ||
          bus_err !== 1'b0 || rdata !== exp_rdata) begin
        n_err++;
        $display("FAIL %s idle: done=%b stall=%b mreq=%b mis=%b err=%b rdata=%h, want rdata %h",
                 name, done, stall, mem_req_valid, misalign, bus_err, rdata, exp_rdata);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({stall, done, rdata, misalign, bus_err, mem_req_valid, mem_addr, mem_wen, mem_wmask,
         mem_wdata} !== '0) begin
      n_err++;
      $display("FAIL reset: outputs not zero, stall=%b done=%b rdata=%h mreq=%b", stall, done,
               rdata, mem_req_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle_check(2, 64'h0, "post_reset");
  endtask

  task automatic test_load_extend();
    run_access(1'b0, 3'b100, 64'h1003, 64'h0, 8'h00, 64'h0000_0000_8000_0000, 0, 0,
               64'h1000, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, "load_b");
    idle_check(2, 64'hFFFF_FFFF_FFFF_FF80, "load_b");
    run_access(1'b0, 3'b101, 64'h2004, 64'h0, 8'h00, 64'h8765_4321_0000_0000, 0, 0,
               64'h2000, 64'h0, 8'h00, 64'h0000_0000_8765_4321, 1'b0, "load_wu");
    idle_check(1, 64'h0000_0000_8765_4321, "load_wu");
    run_access(1'b0, 3'b010, 64'h2004, 64'h0, 8'h00, 64'h8765_4321_0000_0000, 1, 2,
               64'h2000, 64'h0, 8'h00, 64'hFFFF_FFFF_8765_4321, 1'b0, "load_w");
    idle_check(1, 64'hFFFF_FFFF_8765_4321, "load_w");
    run_access(1'b0, 3'b110, 64'h5002, 64'h0, 8'h00, 64'h0000_0000_ABCD_0000, 0, 0,
               64'h5000, 64'h0, 8'h00, 64'h0000_0000_0000_ABCD, 1'b0, "load_hu");
    idle_check(1, 64'h0000_0000_0000_ABCD, "load_hu");
    run_access(1'b0, 3'b011, 64'h5002, 64'h0, 8'h00, 64'h0000_0000_ABCD_0000, 0, 0,
               64'h5000, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_ABCD, 1'b0, "load_h");
    idle_check(1, 64'hFFFF_FFFF_FFFF_ABCD, "load_h");
    run_access(1'b0, 3'b001, 64'h6000, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF, 0, 1,
               64'h6000, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF, 1'b0, "load_d");
    idle_check(1, 64'h0123_4567_89AB_CDEF, "load_d");
  endtask

  task automatic test_store_stall();
    run_access(1'b1, 3'b011, 64'h3006, 64'h0000_0000_0000_BEEF, 8'hC0, 64'hDEAD_BEEF_DEAD_BEEF,
               3, 0, 64'h3000, 64'hBEEF_0000_0000_0000, 8'hC0, 64'h0, 1'b0, "store_h");
    idle_check(2, 64'h0123_4567_89AB_CDEF, "store_h");
  endtask

  task automatic test_misalign();
    logic [2:0]  widths [6];
    logic [63:0] addrs  [6];
    logic        want   [6];
    widths = '{3'b001, 3'b010, 3'b101, 3'b011, 3'b110, 3'b000};
    addrs  = '{64'h4004, 64'h2002, 64'h2006, 64'h3001, 64'h3003, 64'h4004};
    want   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b0; req_width = widths[i]; req_addr = addrs[i];
      @(negedge clk);
      n_vec++;
      if (misalign !== want[i] || stall !== 1'b0 || mem_req_valid !== 1'b0) begin
        n_err++;
        $display("FAIL misalign[%0d]: misalign=%b stall=%b mreq=%b, want %b 0 0", i, misalign,
                 stall, mem_req_valid, want[i]);
      end
      idle_check(1, 64'h0123_4567_89AB_CDEF, "misalign_after");
    end
  endtask

  task automatic test_timeout();
    run_access(1'b0, 3'b010, 64'h9000, 64'h0, 8'h00, 64'h1111_2222_3333_4444, 0, -1,
               64'h9000, 64'h0, 8'h00, 64'h0, 1'b1, "timeout");
    idle_check(2, 64'h0, "timeout");
  endtask

  task automatic test_reset_in_wait();
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_width = 3'b010; req_addr = 64'hA000;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    n_vec++;
    if (stall !== 1'b1 || mem_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_wait pre: stall=%b mreq=%b, want 1 0", stall, mem_req_valid);
    end
    rst = 1'b1; req_valid = 1'b0; mem_req_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({stall, done, rdata, misalign, bus_err, mem_req_valid, mem_addr, mem_wen, mem_wmask,
         mem_wdata} !== '0) begin
      n_err++;
      $display("FAIL rst_wait outputs: stall=%b done=%b rdata=%h mreq=%b, want all 0", stall,
               done, rdata, mem_req_valid);
    end
    mem_resp_valid = 1'b1; mem_resp_data = 64'h5555_5555_5555_5555;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0 || rdata !== 64'h0) begin
        n_err++;
        $display("FAIL rst_wait late_resp: done=%b rdata=%h, want 0 0", done, rdata);
      end
    end
    mem_resp_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_access(1'b0, 3'b111, 64'h7007, 64'h0, 8'h00, 64'hF100_0000_0000_0000, 0, 0,
               64'h7000, 64'h0, 8'h00, 64'h0000_0000_0000_00F1, 1'b0, "b2b_load");
    run_access(1'b1, 3'b001, 64'h8000, 64'h1122_3344_5566_7788, 8'hFF, 64'h0, 0, 0,
               64'h8000, 64'h1122_3344_5566_7788, 8'hFF, 64'h0, 1'b0, "b2b_store");
    idle_check(3, 64'h0000_0000_0000_00F1, "b2b");
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard: %0d completions outstanding, want 0", sb_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 64'h0; req_wdata = 64'h0;
    req_width = 3'b000; req_wmask = 8'h00; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    mem_resp_data = 64'h0;
    test_reset();
    test_load_extend();
    test_store_stall();
    test_misalign();
    test_timeout();
    test_reset_in_wait();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
